// File: rtl/sdram_arbiter.sv
// Fixed-priority (vid > cpu > ldr) arbiter for one ssdram port, with a loader starvation guard.
// Grant edge -> ACCESS_CYCLES clocks of cs -> one DONE clock with ack; requesters hold req until ack.
module sdram_arbiter #(
    parameter int AW            = 24,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 6,
    parameter int MAX_WAIT      = 7
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic          vid_ack_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    input  logic          ldr_req_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic          ldr_ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i,
    output logic          ram_cs_o,
    output logic          ram_oe_o,
    output logic          ram_we_o
);
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_LDR} grant_t;

    state_t        state_q, state_d;
    grant_t        grant_q, grant_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    wait_q, wait_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                grant_d = G_NONE;
                if (ldr_req_i && wait_q == WAIT_MAX) grant_d = G_LDR;
                else if (vid_req_i)                  grant_d = G_VID;
                else if (cpu_req_i)                  grant_d = G_CPU;
                else if (ldr_req_i)                  grant_d = G_LDR;
                case (grant_d)
                    G_VID: begin addr_d = vid_addr_i; wdata_d = '0;          we_d = 1'b0;     end
                    G_CPU: begin addr_d = cpu_addr_i; wdata_d = cpu_wdata_i; we_d = cpu_we_i; end
                    G_LDR: begin addr_d = ldr_addr_i; wdata_d = ldr_wdata_i; we_d = 1'b1;     end
                    default: ;
                endcase
                if (grant_d != G_NONE) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
                // A loss only counts against the loader while it is actually waiting.
                if (grant_d == G_LDR)
                    wait_d = '0;
                else if (grant_d != G_NONE && ldr_req_i && wait_q != WAIT_MAX)
                    wait_d = wait_q + 4'd1;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = ram_data_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!ldr_req_i) wait_d = '0;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            grant_q <= G_NONE;
            cnt_q   <= '0;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    assign ram_cs_o   = (state_q == ACCESS);
    assign ram_we_o   = ram_cs_o && we_q;
    assign ram_oe_o   = ram_cs_o && !we_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = wdata_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q != IDLE);
    assign vid_ack_o  = (state_q == DONE) && (grant_q == G_VID);
    assign cpu_ack_o  = (state_q == DONE) && (grant_q == G_CPU);
    assign ldr_ack_o  = (state_q == DONE) && (grant_q == G_LDR);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table of single arbitrations plus hand sequences
// for back-to-back ordering, loader starvation, mid-window changes, reset abort and held requests.
module tb_sdram_arbiter;
    localparam int AW  = 24;
    localparam int DW  = 8;
    localparam int ACC = 6;
    localparam int MW  = 3;

    logic          clock_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          vid_req_i = 1'b0, cpu_req_i = 1'b0, ldr_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [AW-1:0] vid_addr_i = '0, cpu_addr_i = '0, ldr_addr_i = '0;
    logic [DW-1:0] cpu_wdata_i = '0, ldr_wdata_i = '0, ram_data_i = '0;
    logic          vid_ack_o, cpu_ack_o, ldr_ack_o, busy_o, ram_cs_o, ram_oe_o, ram_we_o;
    logic [DW-1:0] rdata_o, ram_data_o;
    logic [AW-1:0] ram_addr_o;

    sdram_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(ACC), .MAX_WAIT(MW)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_ack_o(vid_ack_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o),
        .ldr_req_i(ldr_req_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
        .ldr_ack_o(ldr_ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Follows one access from cs rise to its DONE clock; returns at the DONE negedge.
    task automatic observe(input string name, input logic [2:0] exp_ack, input logic exp_we,
                           input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wd,
                           input logic [DW-1:0] rd_val, input logic [DW-1:0] exp_rd,
                           input logic perturb, output int cs_cyc, output int ack_cyc);
        int guard;
        int n;
        guard = 0; n = 0; cs_cyc = 0; ack_cyc = 0;
        do begin
            @(negedge clock_i);
            guard++;
        end while (!ram_cs_o && guard < 40);
        chk({name, "/cs_start"}, 32'(ram_cs_o), 32'd1);
        if (!ram_cs_o) return;
        cs_cyc = cyc;
        while (ram_cs_o && n < 20) begin
            n++;
            chk({name, "/addr"}, 32'(ram_addr_o), 32'(exp_addr));
            chk({name, "/we"}, 32'(ram_we_o), 32'(exp_we));
            chk({name, "/oe"}, 32'(ram_oe_o), 32'(!exp_we));
            chk({name, "/ack_in_window"}, 32'({vid_ack_o, cpu_ack_o, ldr_ack_o}), 32'd0);
            if (exp_we) chk({name, "/wdata"}, 32'(ram_data_o), 32'(exp_wd));
            if (perturb && n == 2) begin
                cpu_addr_i = 24'h002000;
                vid_addr_i = 24'h0F0F0F;
            end
            ram_data_i = (n == ACC) ? rd_val : ~rd_val;
            @(negedge clock_i);
        end
        ack_cyc = cyc;
        chk({name, "/cs_len"}, 32'(n), 32'(ACC));
        chk({name, "/ack"}, 32'({vid_ack_o, cpu_ack_o, ldr_ack_o}), 32'(exp_ack));
        chk({name, "/rdata"}, 32'(rdata_o), 32'(exp_rd));
        chk({name, "/busy_done"}, 32'(busy_o), 32'd1);
    endtask

    task automatic quiet(input string name, input int ncyc);
        int hits;
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock_i);
            if (ram_cs_o || vid_ack_o || cpu_ack_o || ldr_ack_o) hits++;
        end
        chk(name, 32'(hits), 32'd0);
    endtask

    typedef struct {
        logic          vid, cpu, ldr, cpu_we;
        logic [AW-1:0] vaddr, caddr, laddr;
        logic [DW-1:0] cwd, lwd, rd;
        logic [2:0]    exp_ack;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd, exp_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, a1, c2, a2, c3, a3;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000123, 24'h000000, 8'h00, 8'h00, 8'hA5, 3'b010, 1'b0, 24'h000123, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 24'h000000, 24'h000000, 8'h00, 8'h00, 8'h3C, 3'b100, 1'b0, 24'hABCDEF, 8'h00, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'h00FFFF, 24'h000000, 8'h5A, 8'h00, 8'h77, 3'b010, 1'b1, 24'h00FFFF, 8'h5A, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 24'h800000, 8'h00, 8'hC3, 8'h66, 3'b001, 1'b1, 24'h800000, 8'hC3, 8'h3C};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000010, 24'h000020, 24'h000000, 8'h00, 8'h00, 8'h11, 3'b100, 1'b0, 24'h000010, 8'h00, 8'h11};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000030, 24'h000040, 8'h99, 8'h88, 8'h22, 3'b010, 1'b0, 24'h000030, 8'h00, 8'h22};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h000050, 24'h000000, 24'h000060, 8'h00, 8'h55, 8'h33, 3'b100, 1'b0, 24'h000050, 8'h00, 8'h33};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h000070, 24'h000080, 24'h000090, 8'hAA, 8'hBB, 8'h44, 3'b100, 1'b0, 24'h000070, 8'h00, 8'h44};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h0000A0, 24'h0000B0, 8'hCC, 8'hDD, 8'hEE, 3'b010, 1'b1, 24'h0000A0, 8'hCC, 8'h44};

        // Reset state
        cpu_req_i = 1'b1;
        #23;
        chk("rst/strobes", 32'({ram_cs_o, ram_oe_o, ram_we_o, busy_o}), 32'd0);
        chk("rst/acks", 32'({vid_ack_o, cpu_ack_o, ldr_ack_o}), 32'd0);
        chk("rst/addr", 32'(ram_addr_o), 32'd0);
        chk("rst/data", 32'({ram_data_o, rdata_o}), 32'd0);
        cpu_req_i = 1'b0;
        @(negedge clock_i);
        reset_n_i = 1'b1;
        quiet("idle_no_req", 4);

        foreach (vecs[i]) begin
            vid_req_i = vecs[i].vid; cpu_req_i = vecs[i].cpu; ldr_req_i = vecs[i].ldr;
            cpu_we_i = vecs[i].cpu_we; vid_addr_i = vecs[i].vaddr; cpu_addr_i = vecs[i].caddr;
            ldr_addr_i = vecs[i].laddr; cpu_wdata_i = vecs[i].cwd; ldr_wdata_i = vecs[i].lwd;
            observe($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_we, vecs[i].exp_addr,
                    vecs[i].exp_wd, vecs[i].rd, vecs[i].exp_rd, 1'b0, c1, a1);
            vid_req_i = 1'b0; cpu_req_i = 1'b0; ldr_req_i = 1'b0;
            quiet($sformatf("vec%0d/single", i), 3);
        end

        // Simultaneous requests: vid, cpu, ldr, acks 8 clocks apart
        vid_addr_i = 24'h000100; cpu_addr_i = 24'h000200; ldr_addr_i = 24'h000300;
        cpu_we_i = 1'b0; ldr_wdata_i = 8'h5C;
        vid_req_i = 1'b1; cpu_req_i = 1'b1; ldr_req_i = 1'b1;
        observe("all3/vid", 3'b100, 1'b0, 24'h000100, 8'h00, 8'h71, 8'h71, 1'b0, c1, a1);
        vid_req_i = 1'b0;
        observe("all3/cpu", 3'b010, 1'b0, 24'h000200, 8'h00, 8'h72, 8'h72, 1'b0, c2, a2);
        cpu_req_i = 1'b0;
        observe("all3/ldr", 3'b001, 1'b1, 24'h000300, 8'h5C, 8'h00, 8'h72, 1'b0, c3, a3);
        ldr_req_i = 1'b0;
        chk("all3/gap12", 32'(a2 - a1), 32'd8);
        chk("all3/gap23", 32'(a3 - a2), 32'd8);
        quiet("all3/quiet", 3);

        // Starvation guard: ldr wins every 4th arbitration, counter restarts after its grant
        vid_addr_i = 24'h000400; ldr_addr_i = 24'h000500; ldr_wdata_i = 8'h3A;
        vid_req_i = 1'b1; cpu_req_i = 1'b1; ldr_req_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++)
                observe($sformatf("starve%0d/vid%0d", r, k), 3'b100, 1'b0, 24'h000400, 8'h00,
                        8'(8'h61 + 3 * r + k), 8'(8'h61 + 3 * r + k), 1'b0, c1, a1);
            observe($sformatf("starve%0d/ldr", r), 3'b001, 1'b1, 24'h000500, 8'h3A, 8'h00,
                    8'(8'h63 + 3 * r), 1'b0, c1, a1);
        end
        vid_req_i = 1'b0; cpu_req_i = 1'b0; ldr_req_i = 1'b0;
        quiet("starve/quiet", 3);

        // Address change during the window is ignored
        cpu_addr_i = 24'h001000; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
        observe("addr_hold", 3'b010, 1'b0, 24'h001000, 8'h00, 8'h8E, 8'h8E, 1'b1, c1, a1);
        cpu_req_i = 1'b0;
        quiet("addr_hold/quiet", 3);

        // Reset on the 3rd ACCESS clock aborts without ack
        cpu_addr_i = 24'h000777; cpu_req_i = 1'b1;
        begin
            int g;
            g = 0;
            do begin @(negedge clock_i); g++; end while (!ram_cs_o && g < 40);
            chk("rst_mid/cs_start", 32'(ram_cs_o), 32'd1);
        end
        @(negedge clock_i);
        @(negedge clock_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_mid/cs_drop", 32'({ram_cs_o, ram_oe_o, busy_o}), 32'd0);
        chk("rst_mid/acks", 32'({vid_ack_o, cpu_ack_o, ldr_ack_o}), 32'd0);
        chk("rst_mid/rdata", 32'(rdata_o), 32'd0);
        quiet("rst_mid/hold", 3);
        reset_n_i = 1'b1;
        observe("rst_mid/fresh", 3'b010, 1'b0, 24'h000777, 8'h00, 8'h9D, 8'h9D, 1'b0, c1, a1);
        cpu_req_i = 1'b0;
        quiet("rst_mid/one_ack", 10);

        // Request held through its ack repeats two clocks later; dropping it stops repeats
        cpu_addr_i = 24'h004321; cpu_req_i = 1'b1;
        observe("held/first", 3'b010, 1'b0, 24'h004321, 8'h00, 8'h5E, 8'h5E, 1'b0, c1, a1);
        observe("held/second", 3'b010, 1'b0, 24'h004321, 8'h00, 8'hE5, 8'hE5, 1'b0, c2, a2);
        cpu_req_i = 1'b0;
        chk("held/gap", 32'(c2 - a1), 32'd2);
        quiet("held/no_third", 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single ssdram port (addr/data/cs/oe/we) between three requesters: video fetch, Z80 CPU and the HPS ROM/tape loader.
- Runs on the SDRAM controller clock.
- Sequences each access as a fixed-length cs window, captures read data and returns a one-cycle acknowledge to the winning requester.
- Fixed priority, with a starvation guard for the loader.

Parameters:
- AW, 24, address width, all requesters and the SDRAM side.
- DW, 8, data width.
- ACCESS_CYCLES, 6, clocks cs_o is held per access (ssdram latency at 96 MHz); legal range 2..15.
- MAX_WAIT, 7, consecutive lost arbitrations after which a pending loader request wins; legal range 1..15.

Ports:
- clock_i  in  1  SDRAM-domain clock.
- reset_n_i  in  1  asynchronous active-low reset.
- vid_req_i  in  1  video request; level, held until vid_ack_o.
- vid_addr_i  in  AW  video read address.
- vid_ack_o  out  1  one-cycle pulse; rdata_o valid.
- cpu_req_i  in  1  CPU request; level, held until cpu_ack_o.
- cpu_we_i  in  1  CPU write (1) / read (0).
- cpu_addr_i  in  AW  CPU address.
- cpu_wdata_i  in  DW  CPU write data.
- cpu_ack_o  out  1  one-cycle pulse.
- ldr_req_i  in  1  loader request; level, held until ldr_ack_o; always a write.
- ldr_addr_i  in  AW  loader address.
- ldr_wdata_i  in  DW  loader write data.
- ldr_ack_o  out  1  one-cycle pulse.
- rdata_o  out  DW  read data of the last completed read; holds until the next read completes.
- busy_o  out  1  high whenever state is not IDLE.
- ram_addr_o  out  AW  to ssdram addr_i.
- ram_data_o  out  DW  to ssdram data_i.
- ram_data_i  in  DW  from ssdram data_o.
- ram_cs_o  out  1  to ssdram cs_i.
- ram_oe_o  out  1  to ssdram oe_i.
- ram_we_o  out  1  to ssdram we_i.

Behaviour:
- Reset (asynchronous, reset_n_i low) forces:
  - state IDLE
  - all ack/cs/oe/we outputs 0
  - ram_addr_o, ram_data_o, rdata_o cleared to 0
  - wait counter 0
  - grant none
- Reset asserted mid-access aborts the access with no ack issued; requesters must re-request.
- States: IDLE -> ACCESS -> DONE -> IDLE. No other transitions.
- IDLE: sample the requests.
  - Normal priority: vid > cpu > ldr.
  - If ldr_req_i is high and wait_cnt == MAX_WAIT, ldr wins regardless of the others.
  - On any grant, register the winner's addr, wdata and we (vid: we=0; ldr: we=1) into ram_* outputs, load cycle counter = ACCESS_CYCLES-1, go to ACCESS.
  - No request: stay in IDLE, all ram_cs/oe/we = 0.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each grant to another requester while ldr_req_i is high.
  - Clears on ldr grant, and whenever ldr_req_i is low.
- ACCESS:
  - ram_cs_o = 1. ram_we_o = we. ram_oe_o = ~we.
  - ram_addr_o and ram_data_o remain stable for the whole window; requester input changes are ignored.
  - Counter decrements each clock. When it reaches 0:
    - on a read, capture ram_data_i into rdata_o;
    - go to DONE.
  - cs_o is high for exactly ACCESS_CYCLES clocks.
- DONE (exactly 1 clock):
  - ram_cs/oe/we = 0.
  - Pulse the granted requester's ack for this clock.
  - Return to IDLE.
- Minimum gap between cs windows is 2 clocks (DONE + IDLE). Back-to-back throughput is one access per ACCESS_CYCLES+2 clocks.
- Latency: request high in IDLE at edge t -> cs_o high from t+1 -> ack at t+1+ACCESS_CYCLES. rdata_o is valid on the same edge as ack and stays valid afterwards.
- A request still high during its own ack cycle is treated as a new request in the following IDLE. Requesters must drop req in the ack cycle to avoid a repeat access.
- A request that arrives or changes while another access is in progress does not affect that access. It is arbitrated in the next IDLE.
- At most one ack is high per clock; acks never occur outside DONE.

Test Plan:
- Single CPU read, ACCESS_CYCLES=6, ram_data_i=0xA5 at the final ACCESS clock:
  - cs_o high for 6 clocks, oe_o=1, we_o=0;
  - cpu_ack_o pulses at the 7th clock after the grant edge;
  - rdata_o=0xA5 and holds.
- Simultaneous vid, cpu and ldr requests at the same edge:
  - grant order is vid, cpu, ldr;
  - three ack pulses spaced 8 clocks apart;
  - the ldr access has we_o=1 and ram_data_o=ldr_wdata_i.
- Starvation guard, MAX_WAIT=3, ldr held high while vid and cpu re-request continuously:
  - ldr granted on the 4th arbitration;
  - wait counter returns to 0 afterwards.
- Requester address changed mid-ACCESS (cpu_addr_i 0x001000 -> 0x002000):
  - ram_addr_o stays 0x001000 for the whole window.
- reset_n_i pulled low on the 3rd ACCESS clock:
  - cs_o drops immediately (asynchronously);
  - no ack is issued;
  - after release with the request still high, a full fresh access completes with one ack.
- Request held high through its ack:
  - a second identical access starts 2 clocks after the first ack;
  - dropping req in the ack cycle yields exactly one access.
